// File: rtl/neuron_mac_responder.sv
// neuron_mac_responder: buffers signed (input, weight) pairs on wr_en. On rd_en it
// accumulates their products one per cycle, then saturates the sum to OUT_W bits
// (ReLU is optional). The result is held until output_ready acknowledges it.
module neuron_mac_responder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int OUT_W  = 16,
    parameter int RELU   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic signed [DATA_W-1:0]   wr_data,
    input  logic signed [DATA_W-1:0]   wr_weight,
    input  logic                       rd_en,
    input  logic                       output_ready,
    output logic signed [OUT_W-1:0]    result,
    output logic                       result_valid,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       wr_drop,
    output logic                       sat
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = IDX_W + 1;
    localparam int PROD_W = 2 * DATA_W;
    // Accumulator holds DEPTH full-precision products plus a sign bit, so it cannot wrap.
    // The clip bounds below assume ACC_W >= OUT_W, which holds for any sensible sizing.
    localparam int ACC_W  = PROD_W + IDX_W + 1;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        $signed({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_SAT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_count;
    logic [CNT_W-1:0]          r_idx;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [OUT_W-1:0]   r_result;
    logic                      r_valid;
    logic                      r_sat;
    logic                      r_drop;
    logic signed [DATA_W-1:0]  r_data [DEPTH];
    logic signed [DATA_W-1:0]  r_wgt  [DEPTH];

    logic                      w_full;
    logic                      w_wr_ok;
    logic                      w_last;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;

    // True when the accumulated value lies outside the OUT_W signed range.
    function automatic logic sat_clipped(input logic signed [ACC_W-1:0] a);
        return (a > SAT_MAX) || (a < SAT_MIN);
    endfunction

    // Clamp the accumulated value to the OUT_W signed range.
    function automatic logic signed [OUT_W-1:0] sat_clip(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (a < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        else
            return a[OUT_W-1:0];
    endfunction

    // Optional rectifier applied after clipping; the sat flag ignores it.
    function automatic logic signed [OUT_W-1:0] relu_fn(input logic signed [OUT_W-1:0] v);
        if (RELU != 0 && v[OUT_W-1])
            return '0;
        else
            return v;
    endfunction

    assign w_full     = (r_count == FULL);
    assign w_wr_ok    = (r_state == S_IDLE) && wr_en && !w_full;
    assign w_last     = (r_idx == r_count - CNT_W'(1));
    assign w_prod     = r_data[r_idx[IDX_W-1:0]] * r_wgt[r_idx[IDX_W-1:0]];
    assign w_prod_ext = ACC_W'(w_prod);

    // Pair buffer: data only, written at the next free slot while idle.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_data[r_count[IDX_W-1:0]] <= wr_data;
            r_wgt[r_count[IDX_W-1:0]]  <= wr_weight;
        end
    end

    // Control FSM: fill -> multiply-accumulate -> saturate -> hold until acknowledged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_sat    <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= wr_en && ((r_state != S_IDLE) || w_full);
            case (r_state)
                S_IDLE: begin
                    if (w_wr_ok)
                        r_count <= r_count + CNT_W'(1);
                    if (rd_en) begin
                        r_acc <= '0;
                        r_idx <= '0;
                        // A write on the same edge is already counted as an entry.
                        if (w_wr_ok || (r_count != '0))
                            r_state <= S_MAC;
                        else
                            r_state <= S_SAT;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_idx <= r_idx + CNT_W'(1);
                    if (w_last)
                        r_state <= S_SAT;
                end
                S_SAT: begin
                    r_result <= relu_fn(sat_clip(r_acc));
                    r_sat    <= sat_clipped(r_acc);
                    r_valid  <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (output_ready) begin
                        r_valid <= 1'b0;
                        r_sat   <= 1'b0;
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result       = r_result;
    assign result_valid = r_valid;
    assign busy         = (r_state != S_IDLE);
    assign count        = r_count;
    assign wr_drop      = r_drop;
    assign sat          = r_sat;

endmodule
